plic_arbiter: RTL and testbench

Platform-level interrupt arbiter that feeds the core's trap unit.
- Captures up to SRC_NUM external interrupt lines through per-source gateways.
- Selects the highest-priority enabled pending source above a threshold and offers its ID on the ex_trap valid/ready/complete interface.
- Blocks re-triggering of a source until the trap unit signals completion for that ID.
- Configured through a small word-addressed register port driven by the system bus.

---
 rtl/plic_arbiter_pkg.sv | 40 ++++
 rtl/plic_arbiter_if.sv | 29 ++
 rtl/plic_gateway.sv | 57 +++++
 rtl/plic_arbiter.sv | 176 +++++++++++++++++
 tb/tb_plic_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_arbiter_pkg.sv
// Shared constants, register offsets, FSM encoding and status layout for the
// platform-level interrupt arbiter.
package plic_arbiter_pkg;

    localparam int unsigned PLIC_SRC_NUM           = 16;
    localparam int unsigned PLIC_PRIO_W            = 3;
    localparam int unsigned PLIC_ID_W              = 5;
    localparam int unsigned PLIC_ADDR_W            = 6;
    localparam int unsigned PLIC_DATA_W            = 32;
    localparam int unsigned PLIC_MCAUSE_EXT_OFFSET = 4;
    localparam int unsigned PLIC_ERR_BIT           = 8;

    // Word addresses of the configuration registers
    localparam logic [PLIC_ADDR_W-1:0] PLIC_ENABLE    = 6'h00;
    localparam logic [PLIC_ADDR_W-1:0] PLIC_EDGE      = 6'h01;
    localparam logic [PLIC_ADDR_W-1:0] PLIC_THRESH    = 6'h02;
    localparam logic [PLIC_ADDR_W-1:0] PLIC_PENDING   = 6'h03;
    localparam logic [PLIC_ADDR_W-1:0] PLIC_STATUS    = 6'h04;
    localparam logic [PLIC_ADDR_W-1:0] PLIC_PRIO_BASE = 6'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } plic_state_e;

    // Status register image: {err[8], state[7:6], rsvd[5], claimed_id[4:0]}
    typedef struct packed {
        logic                 err;
        plic_state_e          state;
        logic                 rsvd;
        logic [PLIC_ID_W-1:0] claimed_id;
    } plic_status_t;

    // mcause code the trap unit uses for a given external source ID
    function automatic logic [PLIC_ID_W-1:0] plic_mcause(input logic [PLIC_ID_W-1:0] id);
        return id + PLIC_ID_W'(PLIC_MCAUSE_EXT_OFFSET);
    endfunction

endpackage

// File: rtl/plic_arbiter_if.sv
// Configuration bus and ex_trap handshake between the arbiter (slave) and
// the system bus / trap unit (master).
interface plic_arbiter_if;
    import plic_arbiter_pkg::*;

    logic                   cfg_we_i;
    logic                   cfg_re_i;
    logic [PLIC_ADDR_W-1:0] cfg_addr_i;
    logic [PLIC_DATA_W-1:0] cfg_wdata_i;
    logic [PLIC_DATA_W-1:0] cfg_rdata_o;
    logic                   ex_trap_valid_o;
    logic [PLIC_ID_W-1:0]   ex_trap_id_o;
    logic                   ex_trap_ready_i;
    logic                   ex_trap_cplet_i;
    logic [PLIC_ID_W-1:0]   ex_trap_cplet_id_i;

    modport slave (
        input  cfg_we_i, cfg_re_i, cfg_addr_i, cfg_wdata_i,
        input  ex_trap_ready_i, ex_trap_cplet_i, ex_trap_cplet_id_i,
        output cfg_rdata_o, ex_trap_valid_o, ex_trap_id_o
    );

    modport master (
        output cfg_we_i, cfg_re_i, cfg_addr_i, cfg_wdata_i,
        output ex_trap_ready_i, ex_trap_cplet_i, ex_trap_cplet_id_i,
        input  cfg_rdata_o, ex_trap_valid_o, ex_trap_id_o
    );

endinterface

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: edge/level capture into a pending bit,
// blocked while the source is claimed.
// Ports: irq_i raw line, edge_mode_i 1=rising edge, claim_i clears pending and
// sets claimed, sw_clr_i software pending clear, cplet_i clears claimed,
// pending_o current pending bit.
module plic_gateway (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic claim_i,
    input  logic sw_clr_i,
    input  logic cplet_i,
    output logic pending_o
);

    logic irq_prev_q;
    logic pending_q, pending_d;
    logic claimed_q, claimed_d;
    logic set_req;

    // Set is blocked from the claim cycle onward until completion
    always_comb begin
        set_req   = 1'b0;
        pending_d = pending_q;
        claimed_d = claimed_q;
        if (!(claimed_q || claim_i)) begin
            set_req = edge_mode_i ? (irq_i & ~irq_prev_q) : irq_i;
        end
        if (claim_i || sw_clr_i) begin
            pending_d = 1'b0;
        end
        if (set_req) begin
            pending_d = 1'b1;
        end
        if (claim_i) begin
            claimed_d = 1'b1;
        end else if (cplet_i) begin
            claimed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            claimed_q  <= 1'b0;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= pending_d;
            claimed_q  <= claimed_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/plic_arbiter.sv
// Platform-level interrupt arbiter: per-source gateways, priority/threshold
// arbitration and a one-at-a-time offer/claim/complete handshake to the trap
// unit, configured through a word-addressed register port.
// Ports: clk, rst (async active-high), src_irq_i raw lines, bus = config
// port plus ex_trap valid/id/ready/cplet signals.
module plic_arbiter
    import plic_arbiter_pkg::*;
#(
    parameter int unsigned SRC_NUM = PLIC_SRC_NUM,
    parameter int unsigned PRIO_W  = PLIC_PRIO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SRC_NUM-1:0] src_irq_i,
    plic_arbiter_if.slave      bus
);

    logic [SRC_NUM-1:0]     enable_q, enable_d;
    logic [SRC_NUM-1:0]     edge_q, edge_d;
    logic [PRIO_W-1:0]      thresh_q, thresh_d;
    logic [PRIO_W-1:0]      prio_q [SRC_NUM];
    logic [PRIO_W-1:0]      prio_d [SRC_NUM];
    logic                   err_q, err_d;
    logic [PLIC_DATA_W-1:0] rdata_q, rdata_d;

    plic_state_e            state_q;
    logic                   valid_q;
    logic [PLIC_ID_W-1:0]   id_q;
    logic [PLIC_ID_W-1:0]   claimed_id_q;

    logic [SRC_NUM-1:0]     pending, claim_vec, cplet_vec, sw_clr;
    logic                   claim_fire, cplet_ok, cplet_bad;
    logic                   any_elig;
    logic [PRIO_W-1:0]      best_prio;
    logic [PLIC_ID_W-1:0]   best_id;
    plic_status_t           status;

    for (genvar g = 0; g < SRC_NUM; g++) begin : g_gw
        plic_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .irq_i      (src_irq_i[g]),
            .edge_mode_i(edge_q[g]),
            .claim_i    (claim_vec[g]),
            .sw_clr_i   (sw_clr[g]),
            .cplet_i    (cplet_vec[g]),
            .pending_o  (pending[g])
        );
    end

    assign claim_fire = (state_q == ST_OFFER) && bus.ex_trap_ready_i;
    assign cplet_ok   = (state_q == ST_BUSY) && bus.ex_trap_cplet_i
                        && (bus.ex_trap_cplet_id_i == claimed_id_q);
    assign cplet_bad  = bus.ex_trap_cplet_i && !cplet_ok;

    // One-hot claim / completion strobes to the gateways
    always_comb begin
        claim_vec = '0;
        cplet_vec = '0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            claim_vec[i] = claim_fire && (id_q == PLIC_ID_W'(i));
            cplet_vec[i] = cplet_ok && (claimed_id_q == PLIC_ID_W'(i));
        end
    end

    // Highest priority wins; strict compare keeps the lowest ID on ties
    always_comb begin
        any_elig  = 1'b0;
        best_prio = '0;
        best_id   = '0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            if (pending[i] && enable_q[i] && (prio_q[i] > thresh_q)
                && (prio_q[i] > best_prio)) begin
                any_elig  = 1'b1;
                best_prio = prio_q[i];
                best_id   = PLIC_ID_W'(i);
            end
        end
    end

    // Register writes, software pending clear, error flag and read mux
    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        err_d    = err_q;
        sw_clr   = '0;
        rdata_d  = '0;
        status   = '{err: err_q, state: state_q, rsvd: 1'b0, claimed_id: claimed_id_q};
        if (bus.cfg_we_i) begin
            case (bus.cfg_addr_i)
                PLIC_ENABLE:  enable_d = bus.cfg_wdata_i[SRC_NUM-1:0];
                PLIC_EDGE:    edge_d   = bus.cfg_wdata_i[SRC_NUM-1:0];
                PLIC_THRESH:  thresh_d = bus.cfg_wdata_i[PRIO_W-1:0];
                PLIC_PENDING: sw_clr   = bus.cfg_wdata_i[SRC_NUM-1:0];
                PLIC_STATUS:  if (bus.cfg_wdata_i[PLIC_ERR_BIT]) err_d = 1'b0;
                default: ;
            endcase
            for (int unsigned i = 0; i < SRC_NUM; i++) begin
                if (bus.cfg_addr_i == PLIC_PRIO_BASE + PLIC_ADDR_W'(i)) begin
                    prio_d[i] = bus.cfg_wdata_i[PRIO_W-1:0];
                end
            end
        end
        if (cplet_bad) begin
            err_d = 1'b1;
        end
        if (bus.cfg_re_i) begin
            case (bus.cfg_addr_i)
                PLIC_ENABLE:  rdata_d = PLIC_DATA_W'(enable_q);
                PLIC_EDGE:    rdata_d = PLIC_DATA_W'(edge_q);
                PLIC_THRESH:  rdata_d = PLIC_DATA_W'(thresh_q);
                PLIC_PENDING: rdata_d = PLIC_DATA_W'(pending);
                PLIC_STATUS:  rdata_d = PLIC_DATA_W'(status);
                default: ;
            endcase
            for (int unsigned i = 0; i < SRC_NUM; i++) begin
                if (bus.cfg_addr_i == PLIC_PRIO_BASE + PLIC_ADDR_W'(i)) begin
                    rdata_d = PLIC_DATA_W'(prio_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= '0;
            edge_q   <= '0;
            thresh_q <= '0;
            prio_q   <= '{default: '0};
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            enable_q <= enable_d;
            edge_q   <= edge_d;
            thresh_q <= thresh_d;
            prio_q   <= prio_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Offer FSM: the offer is latched in IDLE and held untouched until ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            id_q         <= '0;
            claimed_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (any_elig) begin
                    id_q    <= best_id;
                    valid_q <= 1'b1;
                    state_q <= ST_OFFER;
                end
                ST_OFFER: if (bus.ex_trap_ready_i) begin
                    valid_q      <= 1'b0;
                    claimed_id_q <= id_q;
                    state_q      <= ST_BUSY;
                end
                ST_BUSY: if (cplet_ok) begin
                    claimed_id_q <= '0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_rdata_o     = rdata_q;
    assign bus.ex_trap_valid_o = valid_q;
    assign bus.ex_trap_id_o    = id_q;

endmodule

// File: tb/tb_plic_arbiter.sv
// Directed self-checking bench for plic_arbiter.
module tb_plic_arbiter;
    import plic_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] src_irq;
    int          n_checks;
    int          n_errors;

    plic_arbiter_if bus_if ();

    plic_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .src_irq_i(src_irq),
        .bus      (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
        bus_if.cfg_we_i    = 1'b1;
        bus_if.cfg_addr_i  = addr;
        bus_if.cfg_wdata_i = data;
        tick();
        bus_if.cfg_we_i    = 1'b0;
        bus_if.cfg_wdata_i = '0;
    endtask

    task automatic cfg_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        bus_if.cfg_re_i   = 1'b1;
        bus_if.cfg_addr_i = addr;
        tick();
        bus_if.cfg_re_i   = 1'b0;
        check(tag, bus_if.cfg_rdata_o, exp);
    endtask

    task automatic pulse(input logic [15:0] mask);
        src_irq = src_irq | mask;
        tick();
        src_irq = src_irq & ~mask;
    endtask

    task automatic claim();
        bus_if.ex_trap_ready_i = 1'b1;
        tick();
        bus_if.ex_trap_ready_i = 1'b0;
    endtask

    task automatic complete(input logic [4:0] id);
        bus_if.ex_trap_cplet_i    = 1'b1;
        bus_if.ex_trap_cplet_id_i = id;
        tick();
        bus_if.ex_trap_cplet_i    = 1'b0;
        bus_if.ex_trap_cplet_id_i = '0;
    endtask

    task automatic check_offer(input string tag, input logic exp_valid, input logic [4:0] exp_id);
        check({tag, "_valid"}, 32'(bus_if.ex_trap_valid_o), 32'(exp_valid));
        if (exp_valid) check({tag, "_id"}, 32'(bus_if.ex_trap_id_o), 32'(exp_id));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        src_irq  = '0;
        bus_if.cfg_we_i           = 1'b0;
        bus_if.cfg_re_i           = 1'b0;
        bus_if.cfg_addr_i         = '0;
        bus_if.cfg_wdata_i        = '0;
        bus_if.ex_trap_ready_i    = 1'b0;
        bus_if.ex_trap_cplet_i    = 1'b0;
        bus_if.ex_trap_cplet_id_i = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_valid", 32'(bus_if.ex_trap_valid_o), 32'd0);
        check("rst_id", 32'(bus_if.ex_trap_id_o), 32'd0);
        cfg_check("rst_status", 6'h04, 32'h0);
        cfg_check("rst_enable", 6'h00, 32'h0);

        // Edge source 3, prio 2, threshold 0
        cfg_write(6'h00, 32'h0008);
        cfg_write(6'h01, 32'h0008);
        cfg_write(6'h13, 32'd2);
        cfg_write(6'h02, 32'd0);
        pulse(16'h0008);
        check_offer("a_pend_cycle", 1'b0, 5'd0);
        tick();
        check_offer("a_offer", 1'b1, 5'd3);
        cfg_check("a_pending", 6'h03, 32'h0008);
        check_offer("a_offer_held", 1'b1, 5'd3);
        claim();
        check_offer("a_claimed", 1'b0, 5'd0);
        cfg_check("a_status_busy", 6'h04, 32'h083);
        cfg_check("a_pending_clr", 6'h03, 32'h0);
        complete(5'd3);
        cfg_check("a_status_idle", 6'h04, 32'h0);

        // Priority order: 9 (prio 6) beats 5 (prio 4)
        cfg_write(6'h00, 32'h0220);
        cfg_write(6'h01, 32'h0220);
        cfg_write(6'h15, 32'd4);
        cfg_write(6'h19, 32'd6);
        pulse(16'h0220);
        tick();
        check_offer("b_win9", 1'b1, 5'd9);
        claim();
        complete(5'd9);
        check_offer("b_gap", 1'b0, 5'd0);
        tick();
        check_offer("b_then5", 1'b1, 5'd5);
        claim();
        complete(5'd5);

        // Tie at prio 3: lowest ID first
        cfg_write(6'h00, 32'h0084);
        cfg_write(6'h01, 32'h0084);
        cfg_write(6'h12, 32'd3);
        cfg_write(6'h17, 32'd3);
        pulse(16'h0084);
        tick();
        check_offer("c_tie2", 1'b1, 5'd2);
        claim();
        complete(5'd2);
        tick();
        check_offer("c_then7", 1'b1, 5'd7);
        claim();
        complete(5'd7);

        // Threshold boundary: prio 4 not above threshold 4
        cfg_write(6'h00, 32'h0002);
        cfg_write(6'h01, 32'h0002);
        cfg_write(6'h11, 32'd4);
        cfg_write(6'h02, 32'd4);
        cfg_check("d_thresh_rd", 6'h02, 32'd4);
        pulse(16'h0002);
        tick();
        tick();
        tick();
        check_offer("d_blocked", 1'b0, 5'd0);
        cfg_write(6'h02, 32'd3);
        check_offer("d_prewrite", 1'b0, 5'd0);
        tick();
        check_offer("d_lowered", 1'b1, 5'd1);
        claim();
        complete(5'd1);
        cfg_write(6'h02, 32'd0);

        // Level source 6 held high through claim and completion
        cfg_write(6'h00, 32'h0040);
        cfg_write(6'h01, 32'h0000);
        cfg_write(6'h16, 32'd5);
        src_irq[6] = 1'b1;
        tick();
        tick();
        check_offer("e_level", 1'b1, 5'd6);
        claim();
        tick();
        tick();
        tick();
        check_offer("e_busy_none", 1'b0, 5'd0);
        cfg_check("e_status", 6'h04, 32'h086);
        complete(5'd6);
        tick();
        tick();
        check_offer("e_reoffer", 1'b1, 5'd6);
        src_irq[6] = 1'b0;
        claim();
        complete(5'd6);
        tick();
        tick();
        check_offer("e_low_quiet", 1'b0, 5'd0);

        // Edge source 0 held high: one offer only
        cfg_write(6'h00, 32'h0001);
        cfg_write(6'h01, 32'h0001);
        cfg_write(6'h10, 32'd1);
        src_irq[0] = 1'b1;
        tick();
        tick();
        check_offer("f_edge", 1'b1, 5'd0);
        claim();
        complete(5'd0);
        tick();
        tick();
        tick();
        check_offer("f_no_reoffer", 1'b0, 5'd0);
        src_irq[0] = 1'b0;

        // Mismatched completion sets sticky err
        cfg_write(6'h00, 32'h0010);
        cfg_write(6'h01, 32'h0010);
        cfg_write(6'h14, 32'd2);
        pulse(16'h0010);
        tick();
        check_offer("g_offer4", 1'b1, 5'd4);
        claim();
        complete(5'd8);
        cfg_check("g_err_busy", 6'h04, 32'h184);
        cfg_write(6'h04, 32'h100);
        cfg_check("g_err_clr", 6'h04, 32'h084);
        complete(5'd4);
        cfg_check("g_idle", 6'h04, 32'h0);
        complete(5'd4);
        cfg_check("g_err_idle", 6'h04, 32'h100);
        cfg_write(6'h04, 32'h100);

        // Unmapped address
        cfg_write(6'h3F, 32'hFFFF_FFFF);
        cfg_check("h_unmapped", 6'h3F, 32'h0);
        cfg_check("h_unmapped5", 6'h05, 32'h0);

        // Reset during OFFER
        cfg_write(6'h00, 32'h0008);
        cfg_write(6'h01, 32'h0008);
        pulse(16'h0008);
        tick();
        check_offer("i_offer", 1'b1, 5'd3);
        rst = 1'b1;
        #1;
        check("i_async_valid", 32'(bus_if.ex_trap_valid_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("i_valid_after", 32'(bus_if.ex_trap_valid_o), 32'd0);
        cfg_check("i_enable", 6'h00, 32'h0);
        cfg_check("i_edge", 6'h01, 32'h0);
        cfg_check("i_thresh", 6'h02, 32'h0);
        cfg_check("i_pending", 6'h03, 32'h0);
        cfg_check("i_status", 6'h04, 32'h0);
        cfg_check("i_prio3", 6'h13, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
